// File: rtl/seq_divider_ctrl.sv
// -----------------------------------------------------------------------------
// seq_divider_ctrl
//   Multi-cycle unsigned restoring divider. A three-state FSM (IDLE/ITER/DONE)
//   drives one shared (N+1)-bit ripple subtractor built from fullsubtract
//   cells. The subtractor performs one trial subtraction per clock, so a
//   division takes N iterations and then one DONE cycle.
//
//   Optional feature macro: DIVZERO_BYPASS_EN
//     defined     : a request whose divisor is 0 goes straight from IDLE to
//                   DONE and loads the saturated result in that same cycle.
//     not defined : a divide-by-zero runs the normal N iterations. The
//                   results are the same either way.
//
// Ports
//   clk          in   single clock; all state changes on the rising edge
//   rst          in   synchronous active-high reset (wins over start)
//   start        in   request; sampled only in IDLE
//   dividend     in   N-bit unsigned dividend, sampled with start
//   divisor      in   N-bit unsigned divisor, sampled with start
//   busy         out  high while iterating
//   done         out  one-cycle pulse; quotient/remainder are valid
//   quotient     out  N-bit result register
//   remainder    out  N-bit result register
//   div_by_zero  out  sampled divisor was 0; held until the next start
// -----------------------------------------------------------------------------

// One-bit full subtractor: o_d = i_a - i_b - i_bin, with borrow out.
module fullsubtract (
    input  logic i_a,
    input  logic i_b,
    input  logic i_bin,
    output logic o_d,
    output logic o_bout
);
    assign o_d    = i_a ^ i_b ^ i_bin;
    assign o_bout = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);
endmodule

module seq_divider_ctrl #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [N:0]    r_rem;        // partial remainder, one bit wider than the operands
    logic [N:0]    r_div;        // latched divisor, MSB always 0
    logic [N-1:0]  r_q;          // dividend shifts out the top, quotient bits shift in the bottom
    logic [CW-1:0] r_cnt;        // iterations still to run
    logic [N-1:0]  r_quotient;
    logic [N-1:0]  r_remainder;
    logic          r_dbz;

    logic [N:0]    w_partial;
    logic [N:0]    w_diff;
    logic [N+1:0]  w_borrow;
    logic          w_bo;
    logic [N:0]    w_rem_next;
    logic [N-1:0]  w_q_next;
    logic          w_last;
    logic          w_bypass;

    // Shift the next dividend bit into the partial remainder, then trial-subtract.
    assign w_partial   = {r_rem[N-1:0], r_q[N-1]};
    assign w_borrow[0] = 1'b0;

    generate
        for (genvar gi = 0; gi <= N; gi++) begin : g_sub
            fullsubtract u_fs (
                .i_a    (w_partial[gi]),
                .i_b    (r_div[gi]),
                .i_bin  (w_borrow[gi]),
                .o_d    (w_diff[gi]),
                .o_bout (w_borrow[gi+1])
            );
        end
    endgenerate

    // A final borrow means the trial went negative: restore (keep the partial
    // remainder) and shift in a 0 quotient bit; otherwise keep the difference.
    assign w_bo       = w_borrow[N+1];
    assign w_rem_next = w_bo ? w_partial : w_diff;
    assign w_q_next   = {r_q[N-2:0], ~w_bo};
    assign w_last     = (r_cnt == CW'(1));

`ifdef DIVZERO_BYPASS_EN
    assign w_bypass = (divisor == '0);
`else
    assign w_bypass = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = w_bypass ? S_DONE : S_ITER;
            S_ITER:  if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem       <= '0;
            r_div       <= '0;
            r_q         <= '0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_div <= {1'b0, divisor};
                        r_rem <= '0;
                        r_q   <= dividend;
                        r_cnt <= CW'(N);
                        r_dbz <= (divisor == '0);
                        // Bypassed divide-by-zero: the N-cycle result is known up front.
                        if (w_bypass) begin
                            r_quotient  <= '1;
                            r_remainder <= dividend;
                        end
                    end
                end
                S_ITER: begin
                    r_rem <= w_rem_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt - CW'(1);
                    // Final remainder is below the divisor, so it fits N bits.
                    if (w_last) begin
                        r_quotient  <= w_q_next;
                        r_remainder <= w_rem_next[N-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (r_state == S_ITER);
    assign done        = (r_state == S_DONE);
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seq_divider_ctrl
//   Self-checking bench for seq_divider_ctrl with N = 4. Each request pushes
//   its expected {quotient, remainder, div_by_zero} onto a scoreboard queue.
//   A negedge monitor pops one entry per done pulse and compares it.
//   Directed vectors come from a table. Hand-written sequences cover the
//   ignored-start case, the mid-operation reset, and an exhaustive sweep.
// -----------------------------------------------------------------------------
module tb_seq_divider_ctrl;

    localparam int N = 4;

`ifdef DIVZERO_BYPASS_EN
    localparam int DZ_LAT = 0;
`else
    localparam int DZ_LAT = N;
`endif

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    seq_divider_ctrl #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] q;
        logic [3:0] r;
        logic       z;
    } vec_t;

    vec_t        vecs[6];
    logic [8:0]  sb_q[$];     // {q, r, z}
    int          total;
    int          bad;
    int          done_cnt;
    logic [3:0]  last_q;
    logic [3:0]  last_r;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard consumer: one entry per done pulse.
    always @(negedge clk) begin
        logic [8:0] e;
        if (done) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got q=%0d r=%0d expected no done", quotient, remainder);
            end else begin
                e = sb_q.pop_front();
                check("sb_quotient", 32'(quotient), 32'(e[8:5]));
                check("sb_remainder", 32'(remainder), 32'(e[4:1]));
                check("sb_div_by_zero", 32'(div_by_zero), 32'(e[0]));
                $display("txn: q=%0d r=%0d dz=%0d (expected %0d %0d %0d)",
                         quotient, remainder, div_by_zero, e[8:5], e[4:1], e[0]);
            end
        end
    end

    // Issue one request, wait for its done, and check latency, busy length and
    // that the previous result holds while the new one is computing.
    task automatic do_div(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] eq, input logic [3:0] er, input logic ez);
        int cyc;
        int busy_cyc;
        int exp_lat;
        cyc = 0;
        while ((busy || done) && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        sb_q.push_back({eq, er, ez});
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        dividend = 4'($urandom);
        divisor  = 4'($urandom);
        cyc      = 0;
        busy_cyc = 0;
        while (!done && cyc < 20) begin
            if (busy) busy_cyc++;
            check("hold_quotient", 32'(quotient), 32'(last_q));
            check("hold_remainder", 32'(remainder), 32'(last_r));
            @(posedge clk); #1;
            cyc++;
        end
        exp_lat = (b == 4'd0) ? DZ_LAT : N;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no done for %0d/%0d expected done within 20 cycles", a, b);
        end else begin
            check("latency", 32'(cyc), 32'(exp_lat));
            check("busy_cycles", 32'(busy_cyc), 32'(exp_lat));
        end
        last_q = eq;
        last_r = er;
    endtask

    initial begin
        int dc0;
        total    = 0;
        bad      = 0;
        done_cnt = 0;
        last_q   = 4'd0;
        last_r   = 4'd0;

        vecs[0] = '{a: 4'd13, b: 4'd3,  q: 4'd4,  r: 4'd1, z: 1'b0};
        vecs[1] = '{a: 4'd15, b: 4'd1,  q: 4'd15, r: 4'd0, z: 1'b0};
        vecs[2] = '{a: 4'd2,  b: 4'd7,  q: 4'd0,  r: 4'd2, z: 1'b0};
        vecs[3] = '{a: 4'd0,  b: 4'd5,  q: 4'd0,  r: 4'd0, z: 1'b0};
        vecs[4] = '{a: 4'd15, b: 4'd15, q: 4'd1,  r: 4'd0, z: 1'b0};
        vecs[5] = '{a: 4'd9,  b: 4'd0,  q: 4'd15, r: 4'd9, z: 1'b1};

        rst      = 1'b1;
        start    = 1'b1;      // reset must win over start
        dividend = 4'd13;
        divisor  = 4'd3;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        check("rst_div_by_zero", 32'(div_by_zero), 32'd0);
        start = 1'b0;
        rst   = 1'b0;
        @(posedge clk); #1;

        // Directed table
        for (int i = 0; i < 6; i++) begin
            do_div(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z);
        end

        // div_by_zero stays set until the next accepted start
        @(posedge clk); #1;
        check("dz_held", 32'(div_by_zero), 32'd1);

        // start during ITER and during DONE is ignored
        dc0 = done_cnt;
        sb_q.push_back({4'd4, 4'd1, 1'b0});
        dividend = 4'd13; divisor = 4'd3; start = 1'b1;
        @(posedge clk); #1;                       // edge 0
        start = 1'b0;
        check("ign_dz_cleared", 32'(div_by_zero), 32'd0);
        @(posedge clk); #1;                       // edge 1
        start = 1'b1; dividend = 4'd7; divisor = 4'd2;
        @(posedge clk); #1;                       // edge 2 samples start in ITER
        start = 1'b0;
        check("ign_busy_iter", 32'(busy), 32'd1);
        @(posedge clk); #1;                       // edge 3
        @(posedge clk); #1;                       // edge 4 -> DONE
        check("ign_done", 32'(done), 32'd1);
        start = 1'b1; dividend = 4'd7; divisor = 4'd2;
        @(posedge clk); #1;                       // edge 5 samples start in DONE
        start = 1'b0;
        check("ign_idle_busy", 32'(busy), 32'd0);
        check("ign_idle_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        check("ign_not_queued", 32'(busy), 32'd0);
        check("ign_done_pulses", 32'(done_cnt - dc0), 32'd1);
        last_q = 4'd4;
        last_r = 4'd1;

        // Reset in the middle of an operation: no done, results cleared
        dc0 = done_cnt;
        do_div(4'd9, 4'd0, 4'd15, 4'd9, 1'b1);    // leave div_by_zero set first
        @(posedge clk); #1;
        dividend = 4'd13; divisor = 4'd3; start = 1'b1;
        @(posedge clk); #1;                       // edge 0
        start = 1'b0;
        @(posedge clk); #1;                       // edge 1
        rst = 1'b1;
        @(posedge clk); #1;                       // edge 2 applies reset
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_quotient", 32'(quotient), 32'd0);
        check("abort_remainder", 32'(remainder), 32'd0);
        check("abort_div_by_zero", 32'(div_by_zero), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("abort_no_done", 32'(done), 32'd0);
        end
        check("abort_done_pulses", 32'(done_cnt - dc0), 32'd1);
        last_q = 4'd0;
        last_r = 4'd0;
        do_div(4'd14, 4'd4, 4'd3, 4'd2, 1'b0);

        // Exhaustive, back to back
        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                do_div(4'(a), 4'(b), 4'(a / b), 4'(a % b), 1'b0);
            end
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
